seq_detector_param: RTL and testbench

Parametrised successor to the hard-coded lab sequence detector. It detects a runtime-loadable serial bit pattern of up to PAT_W bits on a qualified input stream, with overlapping or non-overlapping match modes. It keeps a saturating match counter and exposes detector status. It sits between the board switch/key debounce logic and the LED/HEX display drivers.

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/seq_det_if.sv | 31 +++
 rtl/seq_det_match.sv | 32 +++
 rtl/seq_detector_param.sv | 158 +++++++++++++++
 tb/tb_seq_detector_param.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared status codes, reset defaults and the effective-length helper
// for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] ARMED   = 2'd2;
  localparam logic [1:0] MATCH   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_FILLING = FILLING,
    ST_ARMED   = ARMED,
    ST_MATCH   = MATCH
  } state_e;

  localparam logic [15:0] DEF_PATTERN = 16'b0000_0000_0000_1101;
  localparam int unsigned DEF_LEN     = 32'd4;

  // Requested lengths beyond the history width are clipped to it.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Control/status bundle between the debounce front end (master) and the
// detector (slave).
interface seq_det_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) ();

  logic             enable;
  logic             w;
  logic             load;
  logic [PAT_W-1:0] pattern_in;
  logic [LEN_W-1:0] len_in;
  logic             overlap_in;
  logic             clear_count;
  logic             out_light;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       status;
  logic [LEN_W-1:0] fill;

  modport master (
    output enable, w, load, pattern_in, len_in, overlap_in, clear_count,
    input  out_light, match_count, status, fill
  );

  modport slave (
    input  enable, w, load, pattern_in, len_in, overlap_in, clear_count,
    output out_light, match_count, status, fill
  );

endinterface

// File: rtl/seq_det_match.sv
// Masked compare of the low len_eff history bits against the pattern;
// a zero length never matches.
module seq_det_match #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic [PAT_W-1:0] hist_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_eff_i,
  output logic             match_o
);

  logic [PAT_W-1:0] mask_s;

  // Build a thermometer mask covering bits [len_eff-1:0].
  always_comb begin
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask_s[i] = (i < int'(len_eff_i));
    end
  end

  // Compare only the masked bits; disabled length forces no match.
  always_comb begin
    if (len_eff_i == {LEN_W{1'b0}}) begin
      match_o = 1'b0;
    end else begin
      match_o = (((hist_i ^ pattern_i) & mask_s) == {PAT_W{1'b0}});
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control, a
// saturating match counter and FSM status export.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = 8,
  parameter int unsigned      LEN_W       = 4,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = DEF_PATTERN[PAT_W-1:0],
  parameter logic [LEN_W-1:0] LEN_DEFAULT = LEN_W'(DEF_LEN)
) (
  input  logic     clock,
  input  logic     resetn,
  seq_det_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic             ovl_q,   ovl_d;
  logic [PAT_W-1:0] hist_q,  hist_d;
  logic [LEN_W-1:0] fill_q,  fill_d;
  logic             light_q, light_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  state_e           state_q, state_d;

  logic [LEN_W-1:0] len_eff_s;
  logic [LEN_W-1:0] len_in_eff_s;
  logic [PAT_W-1:0] hist_shift_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic             cmp_eq_s;
  logic             sample_s;
  logic             hit_s;

  assign len_eff_s    = LEN_W'(eff_len(32'(len_q), PAT_W));
  assign len_in_eff_s = LEN_W'(eff_len(32'(bus.len_in), PAT_W));
  assign hist_shift_s = {hist_q[PAT_W-2:0], bus.w};
  assign sample_s     = bus.enable & ~bus.load;

  // Fill count if the current bit were sampled, capped at the effective length.
  always_comb begin
    if (fill_q >= len_eff_s) begin
      fill_inc_s = len_eff_s;
    end else begin
      fill_inc_s = fill_q + LEN_W'(1);
    end
  end

  seq_det_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .hist_i    (hist_shift_s),
    .pattern_i (pat_q),
    .len_eff_i (len_eff_s),
    .match_o   (cmp_eq_s)
  );

  assign hit_s = sample_s & cmp_eq_s & (fill_inc_s == len_eff_s);

  // Next-state for config, history, fill, light and the match counter.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    light_d = light_q;
    cnt_d   = cnt_q;
    if (bus.load) begin
      pat_d   = bus.pattern_in;
      len_d   = bus.len_in;
      ovl_d   = bus.overlap_in;
      hist_d  = {PAT_W{1'b0}};
      fill_d  = {LEN_W{1'b0}};
      light_d = 1'b0;
    end else if (bus.enable) begin
      hist_d  = hist_shift_s;
      light_d = hit_s;
      if (hit_s && !ovl_q) begin
        fill_d = {LEN_W{1'b0}};
      end else begin
        fill_d = fill_inc_s;
      end
    end else begin
      hist_d = hist_q;
    end
    // Clear wins over a same-cycle increment.
    if (bus.clear_count) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (hit_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM next state; only load and sample cycles can move it.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      if (len_in_eff_s == {LEN_W{1'b0}}) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_FILLING;
      end
    end else if (bus.enable) begin
      if (len_eff_s == {LEN_W{1'b0}}) begin
        state_d = ST_IDLE;
      end else if (hit_s) begin
        state_d = ST_MATCH;
      end else if (fill_inc_s == len_eff_s) begin
        state_d = ST_ARMED;
      end else begin
        state_d = ST_FILLING;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and configuration registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pat_q   <= PAT_DEFAULT;
      len_q   <= LEN_DEFAULT;
      ovl_q   <= 1'b1;
      hist_q  <= {PAT_W{1'b0}};
      fill_q  <= {LEN_W{1'b0}};
      light_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      light_q <= light_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.out_light   = light_q;
  assign bus.match_count = cnt_q;
  assign bus.status      = state_q;
  assign bus.fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed plus randomized bench for seq_detector_param, checked against a
// queue-based model of the detection rules.
module tb_seq_detector_param;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  seq_det_if #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) bus ();

  seq_detector_param dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: bits received since the last restart of matching.
  bit       m_q[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_light;
  int       m_cnt;
  int       m_status;

  function automatic int eff(input int len);
    return (len > 8) ? 8 : len;
  endfunction

  function automatic int m_fill();
    int sz = m_q.size();
    return (sz < eff(m_len)) ? sz : eff(m_len);
  endfunction

  function automatic bit model_hit();
    int len = eff(m_len);
    if (len == 0 || m_q.size() < len) return 1'b0;
    for (int i = 0; i < len; i++) begin
      if (m_q[m_q.size() - 1 - i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pat    = 8'b0000_1101;
    m_len    = 4;
    m_ovl    = 1'b1;
    m_light  = 1'b0;
    m_cnt    = 0;
    m_status = 0;
  endtask

  task automatic model_step(input bit en, input bit wv, input bit ld, input bit [7:0] pat,
                            input int len, input bit ovl, input bit clr);
    bit hit = 1'b0;
    if (ld) begin
      m_pat = pat; m_len = len; m_ovl = ovl;
      m_q.delete();
      m_light  = 1'b0;
      m_status = (eff(len) == 0) ? 0 : 1;
    end else if (en) begin
      m_q.push_back(wv);
      if (m_q.size() > 20) void'(m_q.pop_front());
      hit     = model_hit();
      m_light = hit;
      if (hit && !m_ovl) m_q.delete();
      if (eff(m_len) == 0)          m_status = 0;
      else if (hit)                 m_status = 3;
      else if (m_fill() == eff(m_len)) m_status = 2;
      else                          m_status = 1;
    end
    if (clr)                   m_cnt = 0;
    else if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_light"}, 32'(bus.out_light),   32'(m_light));
    chk({tag, "_count"}, 32'(bus.match_count), 32'(m_cnt));
    chk({tag, "_status"}, 32'(bus.status),     32'(m_status));
    chk({tag, "_fill"},  32'(bus.fill),        32'(m_fill()));
  endtask

  // One clock: drive inputs, step the model at the edge, check just after.
  task automatic apply(input string tag, input bit en, input bit wv, input bit ld,
                       input bit [7:0] pat, input int len, input bit ovl, input bit clr);
    bus.enable      = en;
    bus.w           = wv;
    bus.load        = ld;
    bus.pattern_in  = pat;
    bus.len_in      = 4'(len);
    bus.overlap_in  = ovl;
    bus.clear_count = clr;
    @(posedge clock);
    model_step(en, wv, ld, pat, len, ovl, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit       s1 [7]      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int       s1_st [7]   = '{1, 1, 1, 3, 2, 2, 3};
    bit       s1_lt [7]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int       saved_cnt;
    checks   = 0;
    failures = 0;

    bus.enable = 1'b0; bus.w = 1'b0; bus.load = 1'b0; bus.pattern_in = 8'h00;
    bus.len_in = 4'd0; bus.overlap_in = 1'b0; bus.clear_count = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #11;
    model_reset();
    check_all("reset");
    @(negedge clock);
    resetn = 1'b1;

    // 1: default pattern 1101, overlapping.
    for (int i = 0; i < 7; i++) begin
      apply("s1", 1'b1, s1[i], 1'b0, 8'h00, 0, 1'b0, 1'b0);
      chk("s1_status_seq", 32'(bus.status), 32'(s1_st[i]));
      chk("s1_light_seq", 32'(bus.out_light), 32'(s1_lt[i]));
    end
    chk("s1_total", 32'(bus.match_count), 32'd2);

    // 2: non-overlapping mode.
    apply("s2_load", 1'b0, 1'b0, 1'b1, 8'h0D, 4, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) apply("s2", 1'b1, s1[i], 1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("s2_fill", 32'(bus.fill), 32'd3);
    chk("s2_total", 32'(bus.match_count), 32'd1);
    chk("s2_status", 32'(bus.status), 32'd1);

    // 3: counter saturation, then clear on a match cycle.
    apply("s3_load", 1'b0, 1'b0, 1'b1, 8'h01, 1, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) apply("s3", 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("s3_sat", 32'(bus.match_count), 32'd255);
    apply("s3_clr", 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    chk("s3_clr_count", 32'(bus.match_count), 32'd0);
    chk("s3_clr_light", 32'(bus.out_light), 32'd1);

    // 4: disabled length, then an over-long length.
    apply("s4_load0", 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1, 1'b0);
    chk("s4_idle", 32'(bus.status), 32'd0);
    saved_cnt = m_cnt;
    for (int i = 0; i < 20; i++) begin
      apply("s4_off", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 0, 1'b0, 1'b0);
      chk("s4_off_light", 32'(bus.out_light), 32'd0);
      chk("s4_off_count", 32'(bus.match_count), 32'(saved_cnt));
    end
    apply("s4_load15", 1'b0, 1'b0, 1'b1, 8'($urandom), 15, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) apply("s4_long", 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("s4_fill_sat", 32'(bus.fill), 32'd8);

    // 5: scenario 1 with enable gaps and w toggling during them.
    apply("s5_load", 1'b0, 1'b0, 1'b1, 8'h0D, 4, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      apply("s5", 1'b1, s1[i], 1'b0, 8'h00, 0, 1'b0, 1'b0);
      chk("s5_light_seq", 32'(bus.out_light), 32'(s1_lt[i]));
      for (int g = 0; g < 1 + (i % 2); g++) begin
        apply("s5_gap", 1'b0, ~s1[i], 1'b0, 8'h00, 0, 1'b0, 1'b0);
        chk("s5_hold", 32'(bus.out_light), 32'(s1_lt[i]));
      end
    end
    chk("s5_total", 32'(bus.match_count), 32'd2);

    // 6: asynchronous reset in the middle of a pattern.
    apply("s6_load", 1'b0, 1'b0, 1'b1, 8'h0D, 4, 1'b1, 1'b0);
    apply("s6", 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    apply("s6", 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    apply("s6", 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    bus.enable = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("s6_rst_fill", 32'(bus.fill), 32'd0);
    chk("s6_rst_count", 32'(bus.match_count), 32'd0);
    chk("s6_rst_status", 32'(bus.status), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    apply("s6_after", 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    chk("s6_no_match", 32'(bus.out_light), 32'd0);
    chk("s6_fill1", 32'(bus.fill), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int  rlen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 3));
      apply("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 24) == 0), 8'($urandom), rlen,
            1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
